// File: rtl/vcve2_pkg.sv
// rtl/vcve2_pkg.sv - shared types for the fetch bus arbiter
package vcve2_pkg;

  typedef enum logic {
    ARB_SRC_IF  = 1'b0,
    ARB_SRC_VEC = 1'b1
  } fetch_arb_src_e;

  localparam int unsigned FetchArbMaxOutstanding = 8;

endpackage

// File: rtl/cve2_fetch_arb_id_fifo.sv
// rtl/cve2_fetch_arb_id_fifo.sv - in-order FIFO of requester IDs for response routing
module cve2_fetch_arb_id_fifo
  import vcve2_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  fetch_arb_src_e push_src_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output fetch_arb_src_e head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_arb_src_e  mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  // Pointers wrap modulo Depth so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      if (do_push & ~do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (~do_push & do_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_src_i;
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));

endmodule

// File: rtl/cve2_fetch_bus_arbiter.sv
// rtl/cve2_fetch_bus_arbiter.sv - round-robin IF/vector arbiter for the instruction bus
module cve2_fetch_bus_arbiter
  import vcve2_pkg::*;
#(
  parameter int unsigned NumOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        vec_req_i,
  input  logic [31:0] vec_addr_i,
  output logic        vec_gnt_o,
  output logic        vec_rvalid_o,
  output logic [31:0] vec_rdata_o,
  output logic        vec_err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o,
  output logic        protocol_err_o
);

  fetch_arb_src_e sel, sel_q, fifo_head;
  logic           rr_q, lock_q, perr_q;
  logic           locked_req, lock_eff, lock_drop, sel_req;
  logic           fifo_full, fifo_empty, transfer, unexp_rsp;
  logic [31:0]    sel_addr;

  always_comb begin
    locked_req = (sel_q == ARB_SRC_IF) ? if_req_i : vec_req_i;
    lock_eff   = lock_q & locked_req;
    lock_drop  = lock_q & ~locked_req;
    sel        = ARB_SRC_IF;
    if (lock_eff)                  sel = sel_q;
    else if (if_req_i & vec_req_i) sel = rr_q ? ARB_SRC_VEC : ARB_SRC_IF;
    else if (vec_req_i)            sel = ARB_SRC_VEC;
    sel_req  = (sel == ARB_SRC_IF) ? if_req_i : vec_req_i;
    sel_addr = (sel == ARB_SRC_IF) ? if_addr_i : vec_addr_i;
  end

  // Outputs are forced low while reset is held, even though the FIFO is already empty.
  assign instr_req_o  = sel_req & ~fifo_full & ~rst_i;
  assign instr_addr_o = rst_i ? 32'h0 : (sel_addr & 32'hFFFF_FFFC);
  assign transfer     = instr_req_o & instr_gnt_i;
  assign if_gnt_o     = transfer & (sel == ARB_SRC_IF);
  assign vec_gnt_o    = transfer & (sel == ARB_SRC_VEC);
  assign unexp_rsp    = instr_rvalid_i & fifo_empty;

  assign if_rvalid_o  = instr_rvalid_i & ~fifo_empty & (fifo_head == ARB_SRC_IF);
  assign vec_rvalid_o = instr_rvalid_i & ~fifo_empty & (fifo_head == ARB_SRC_VEC);
  assign if_rdata_o   = if_rvalid_o  ? instr_rdata_i : 32'h0;
  assign vec_rdata_o  = vec_rvalid_o ? instr_rdata_i : 32'h0;
  assign if_err_o     = if_rvalid_o  & instr_err_i;
  assign vec_err_o    = vec_rvalid_o & instr_err_i;

  assign busy_o         = ~rst_i & (~fifo_empty | if_req_i | vec_req_i);
  assign protocol_err_o = perr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= 1'b0;
      lock_q <= 1'b0;
      sel_q  <= ARB_SRC_IF;
      perr_q <= 1'b0;
    end else begin
      // A stalled-by-full lock is kept so the same requester is reissued next.
      lock_q <= (instr_req_o & ~instr_gnt_i) | (lock_eff & fifo_full);
      sel_q  <= sel;
      if (transfer)               rr_q   <= (sel == ARB_SRC_IF);
      if (lock_drop | unexp_rsp)  perr_q <= 1'b1;
    end
  end

  cve2_fetch_arb_id_fifo #(
    .Depth(NumOutstanding)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (transfer),
    .push_src_i (sel),
    .pop_i      (instr_rvalid_i),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  assert property (@(posedge clk_i) disable iff (rst_i)
    ($past(instr_req_o & ~instr_gnt_i) & instr_req_o & (sel == $past(sel)))
      |-> (instr_addr_o == $past(instr_addr_o)));

  assert property (@(posedge clk_i) disable iff (rst_i) !(if_rvalid_o && vec_rvalid_o));

endmodule

// File: tb/tb_cve2_fetch_bus_arbiter.sv
// tb/tb_cve2_fetch_bus_arbiter.sv - self-checking bench for the fetch bus arbiter
module tb_cve2_fetch_bus_arbiter;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, vec_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] if_addr, vec_addr, instr_rdata;
  logic        if_gnt_o, if_rvalid_o, if_err_o, vec_gnt_o, vec_rvalid_o, vec_err_o;
  logic        instr_req_o, busy_o, protocol_err_o;
  logic [31:0] if_rdata_o, vec_rdata_o, instr_addr_o;

  int tests = 0;
  int fails = 0;

  // Reference model: outstanding owners in order, requester waiting for grant, last winner.
  int q[$];
  int pend;
  int last;
  bit perr_m;
  bit eg_if, eg_vec;
  logic        obs_req, obs_ig, obs_vg;
  logic [31:0] obs_addr;
  int          gnt_log[$];

  always #5 clk = ~clk;

  cve2_fetch_bus_arbiter #(.NumOutstanding(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .vec_req_i(vec_req), .vec_addr_i(vec_addr), .vec_gnt_o(vec_gnt_o),
    .vec_rvalid_o(vec_rvalid_o), .vec_rdata_o(vec_rdata_o), .vec_err_o(vec_err_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt),
    .instr_rvalid_i(instr_rvalid), .instr_rdata_i(instr_rdata), .instr_err_i(instr_err),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; vec_req = 0; if_addr = 0; vec_addr = 0;
    instr_gnt = 0; instr_rvalid = 0; instr_rdata = 0; instr_err = 0;
  endtask

  task automatic do_reset();
    rst = 1; if_req = 1; vec_req = 1; instr_gnt = 1; instr_rvalid = 0;
    #1;
    chk("rst.instr_req", instr_req_o, 0);
    chk("rst.if_gnt", if_gnt_o, 0);
    chk("rst.vec_gnt", vec_gnt_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.perr", protocol_err_o, 0);
    chk("rst.addr", instr_addr_o, 0);
    @(posedge clk); @(negedge clk);
    q.delete(); pend = -1; last = 1; perr_m = 0;
    idle_inputs();
    rst = 0;
  endtask

  task automatic step(input string tag);
    int w, owner;
    bit viol, full_m, breq, rsp_if, rsp_vec;
    logic [31:0] exp_addr;
    #1;
    w = -1; viol = 0;
    if (pend >= 0) begin
      if ((pend == 0) ? if_req : vec_req) w = pend;
      else viol = 1;
    end
    if (w < 0) begin
      if (if_req && vec_req) w = (last == 0) ? 1 : 0;
      else if (if_req)       w = 0;
      else if (vec_req)      w = 1;
    end
    full_m = (q.size() == N);
    breq   = (w >= 0) && !full_m;
    eg_if  = breq && instr_gnt && (w == 0);
    eg_vec = breq && instr_gnt && (w == 1);
    owner  = (q.size() > 0) ? q[0] : -1;
    rsp_if  = instr_rvalid && (owner == 0);
    rsp_vec = instr_rvalid && (owner == 1);
    exp_addr = (w == 1) ? vec_addr : if_addr;
    exp_addr[1:0] = 2'b00;

    chk({tag, ".instr_req"}, instr_req_o, breq);
    chk({tag, ".if_gnt"}, if_gnt_o, eg_if);
    chk({tag, ".vec_gnt"}, vec_gnt_o, eg_vec);
    if (breq) chk({tag, ".addr"}, instr_addr_o, exp_addr);
    chk({tag, ".if_rvalid"}, if_rvalid_o, rsp_if);
    chk({tag, ".vec_rvalid"}, vec_rvalid_o, rsp_vec);
    chk({tag, ".if_rdata"}, if_rdata_o, rsp_if ? instr_rdata : 32'h0);
    chk({tag, ".vec_rdata"}, vec_rdata_o, rsp_vec ? instr_rdata : 32'h0);
    chk({tag, ".if_err"}, if_err_o, rsp_if && instr_err);
    chk({tag, ".vec_err"}, vec_err_o, rsp_vec && instr_err);
    chk({tag, ".busy"}, busy_o, (q.size() != 0) || if_req || vec_req);
    chk({tag, ".perr"}, protocol_err_o, perr_m);

    obs_req = instr_req_o; obs_addr = instr_addr_o; obs_ig = if_gnt_o; obs_vg = vec_gnt_o;
    if (if_gnt_o)  gnt_log.push_back(0);
    if (vec_gnt_o) gnt_log.push_back(1);

    @(posedge clk);
    if (viol) perr_m = 1;
    if (instr_rvalid) begin
      if (q.size() == 0) perr_m = 1;
      else void'(q.pop_front());
    end
    if (breq && instr_gnt) begin q.push_back(w); last = w; end
    if (breq && !instr_gnt) pend = w;
    else if (!(full_m && w >= 0 && pend == w)) pend = -1;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    do_reset();

    // Single IF stream
    if_req = 1; if_addr = 32'h100; instr_gnt = 1;
    step("if1");
    chk("if1.grant", obs_ig, 1);
    if_addr = 32'h104; instr_rvalid = 1; instr_rdata = 32'hA5A5_0100;
    step("if2");
    if_req = 0; instr_rdata = 32'hA5A5_0104;
    step("if3");
    instr_rvalid = 0; instr_gnt = 0;
    step("if4");

    // Contention: grants alternate starting with IF
    do_reset();
    gnt_log.delete();
    if_req = 1; vec_req = 1; if_addr = 32'h1000; vec_addr = 32'h2001; instr_gnt = 1;
    step("cont0");
    instr_rvalid = 1;
    for (int i = 1; i < 4; i++) begin
      instr_rdata = 32'hC000_0000 + i;
      step("cont");
    end
    if_req = 0; vec_req = 0; instr_rdata = 32'hC000_0004;
    step("cont_drain");
    instr_rvalid = 0;
    chk("cont.ngrants", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("cont.order", gnt_log[i], i % 2);

    // Lock: address held while ungranted, VEC waits
    do_reset();
    gnt_log.delete();
    if_req = 1; vec_req = 1; if_addr = 32'h300; vec_addr = 32'h400; instr_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      step("lock_wait");
      chk("lock.addr", obs_addr, 32'h300);
      chk("lock.vec_gnt", obs_vg, 0);
    end
    instr_gnt = 1;
    step("lock_gnt");
    chk("lock.if_first", obs_ig, 1);
    if_addr = 32'h304;
    step("lock_next");
    chk("lock.vec_after", obs_vg, 1);

    // Full stall with a simultaneous response
    do_reset();
    if_req = 1; if_addr = 32'h200; instr_gnt = 1;
    step("full1");
    if_addr = 32'h204;
    step("full2");
    if_addr = 32'h208; instr_rvalid = 1; instr_rdata = 32'h0000_0200;
    step("full3");
    chk("full.stall", obs_req, 0);
    instr_rvalid = 0;
    step("full4");
    chk("full.reissue", obs_req, 1);
    chk("full.reissue_addr", obs_addr, 32'h208);
    if_req = 0; instr_rvalid = 1;
    step("full_drain1");
    step("full_drain2");
    instr_rvalid = 0;

    // Error routing to VEC
    do_reset();
    vec_req = 1; vec_addr = 32'h500; instr_gnt = 1;
    step("err1");
    vec_req = 0; instr_rvalid = 1; instr_err = 1; instr_rdata = 32'hDEAD_BEEF;
    step("err2");
    instr_rvalid = 0; instr_err = 0;
    step("err3");

    // Unexpected response is sticky until reset
    do_reset();
    instr_rvalid = 1; instr_rdata = 32'h1234;
    step("unexp");
    instr_rvalid = 0;
    for (int i = 0; i < 3; i++) step("unexp_hold");
    chk("unexp.sticky", protocol_err_o, 1);

    // Locked IF dropping its request
    do_reset();
    if_req = 1; if_addr = 32'h600; instr_gnt = 0;
    step("drop1");
    if_req = 0; vec_req = 1; vec_addr = 32'h700; instr_gnt = 1;
    step("drop2");
    chk("drop.vec_granted", obs_vg, 1);
    vec_req = 0;
    step("drop3");
    chk("drop.sticky", protocol_err_o, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (!if_req || eg_if)   begin if_req  = 1'($urandom_range(0, 1)); if_addr  = $urandom; end
      if (!vec_req || eg_vec) begin vec_req = 1'($urandom_range(0, 1)); vec_addr = $urandom; end
      instr_gnt    = ($urandom_range(0, 3) != 0);
      instr_rvalid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      instr_rdata  = $urandom;
      instr_err    = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    // Reset with a transaction outstanding, then a late response
    idle_inputs();
    if_req = 1; if_addr = 32'h800; instr_gnt = 1;
    step("mid1");
    do_reset();
    instr_rvalid = 1; instr_rdata = 32'h0BAD;
    step("late_rsp");
    instr_rvalid = 0;
    step("late_after");
    chk("late.perr", protocol_err_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
